// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared constants and state encoding
// for the bit-serial adder sequencer.
package serial_add_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bit_full_adder.sv
// bit_full_adder: 1-bit full adder from two half adders.
// The single datapath cell stepped by the controller.
module bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s1),
    .c (c1)
  );

  half_adder u_ha1 (
    .a (s1),
    .b (ci),
    .s (s),
    .c (c2)
  );

  assign co = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// half_adder: 1-bit half adder cell.
// Building block of the shared full-adder datapath.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: sequences one full-adder cell over
// WIDTH cycles to produce a registered WIDTH-bit sum.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-2:0] s_sh_q, s_sh_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             cell_s;
  logic             cell_co;
  logic [WIDTH-1:0] s_next;

  bit_full_adder u_cell (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (c_q),
    .s  (cell_s),
    .co (cell_co)
  );

  // s_sh keeps the WIDTH-1 bits already produced; the
  // new bit enters at the top, the final one completes sum.
  assign s_next = {cell_s, s_sh_q};

  // Next-state, shift and counter logic.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        s_sh_d = s_next[WIDTH-1:1];
        c_d    = cell_co;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          sum_d   = s_next;
          cout_d  = cell_co;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared by async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed checks of the
// bit-serial adder with WIDTH=8.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_assert;
  int n_fail;
  int lat;
  int bcnt;
  int dcnt;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Present operands and start before an edge; return
  // 1ns after the accepting edge E0.
  task automatic issue(input logic [W-1:0] av,
                       input logic [W-1:0] bv,
                       input logic cv);
    @(negedge clk);
    a     = av;
    b     = bv;
    cin   = cv;
    start = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Count cycles from now until done, bounded.
  task automatic wait_done(output int l, output int bc);
    l  = 0;
    bc = 0;
    while (!done && l < 30) begin
      if (busy) bc++;
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Zero operands: latency, busy length, done width.
    issue(8'h00, 8'h00, 1'b0);
    start = 1'b0;
    chk("zero_busy0", 32'(busy), 32'd1);
    wait_done(lat, bcnt);
    chk("zero_lat",  32'(lat),  32'd8);
    chk("zero_bcnt", 32'(bcnt), 32'd8);
    chk("zero_sum",  32'(sum),  32'h00);
    chk("zero_cout", 32'(cout), 32'd0);
    @(posedge clk);
    #1;
    chk("zero_done1", 32'(done), 32'd0);
    chk("zero_idle",  32'(busy), 32'd0);

    // Full ripple.
    issue(8'hFF, 8'h01, 1'b0);
    start = 1'b0;
    wait_done(lat, bcnt);
    chk("rip_lat",  32'(lat),  32'd8);
    chk("rip_sum",  32'(sum),  32'h00);
    chk("rip_cout", 32'(cout), 32'd1);

    // Carry-in path, both polarities.
    issue(8'hA5, 8'h5A, 1'b1);
    start = 1'b0;
    wait_done(lat, bcnt);
    chk("ci1_sum",  32'(sum),  32'h00);
    chk("ci1_cout", 32'(cout), 32'd1);
    issue(8'hA5, 8'h5A, 1'b0);
    start = 1'b0;
    wait_done(lat, bcnt);
    chk("ci0_sum",  32'(sum),  32'hFF);
    chk("ci0_cout", 32'(cout), 32'd0);

    // Start held, operands changed during RUN.
    issue(8'h3C, 8'h42, 1'b0);
    a = 8'hFF;
    b = 8'hFF;
    wait_done(lat, bcnt);
    chk("ign_lat",  32'(lat),  32'd8);
    chk("ign_sum",  32'(sum),  32'h7E);
    chk("ign_cout", 32'(cout), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("ign_rerun", 32'(busy), 32'd1);
    wait_done(lat, bcnt);
    chk("ign2_lat",  32'(lat),  32'd8);
    chk("ign2_sum",  32'(sum),  32'hFE);
    chk("ign2_cout", 32'(cout), 32'd1);

    // Back-to-back: second start in the DONE cycle.
    issue(8'h80, 8'h80, 1'b0);
    start = 1'b0;
    wait_done(lat, bcnt);
    chk("b2b1_lat",  32'(lat),  32'd8);
    chk("b2b1_sum",  32'(sum),  32'h00);
    chk("b2b1_cout", 32'(cout), 32'd1);
    a     = 8'h12;
    b     = 8'h34;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_hold", 32'({cout, sum}), 32'h100);
    wait_done(lat, bcnt);
    chk("b2b2_lat",  32'(lat),  32'd8);
    chk("b2b2_sum",  32'(sum),  32'h46);
    chk("b2b2_cout", 32'(cout), 32'd0);

    // Reset between E0+3 and E0+4.
    issue(8'hFF, 8'hFF, 1'b1);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_sum",  32'(sum),  32'd0);
    chk("mr_cout", 32'(cout), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) dcnt++;
    end
    chk("mr_nodone", 32'(dcnt), 32'd0);
    issue(8'h01, 8'h02, 1'b0);
    start = 1'b0;
    wait_done(lat, bcnt);
    chk("mr_lat",  32'(lat),  32'd8);
    chk("mr_sum2", 32'(sum),  32'h03);
    chk("mr_cout2", 32'(cout), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial addition sequencer that computes an N-bit sum by stepping a single 1-bit full-adder cell, built from two half adders, over N clock cycles. It sits between a requester issuing start/operand pulses and the shared 1-bit adder datapath. It latches operands, shifts one bit per cycle through the cell, tracks the carry, and reports completion with a one-cycle done pulse. It trades area for latency: one adder cell regardless of WIDTH.

## Interface
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE or DONE
- a  in  WIDTH  operand A; sampled on the accepting edge only
- b  in  WIDTH  operand B; sampled on the accepting edge only
- cin  in  1  carry-in; sampled on the accepting edge only
- busy  out  1  high while an addition is in progress (RUN state)
- done  out  1  one-cycle completion pulse (DONE state)
- sum  out  WIDTH  registered result (a+b+cin) mod 2^WIDTH
- cout  out  1  registered carry-out, bit WIDTH of a+b+cin

## Operation
- States: IDLE, RUN, DONE. busy = (state==RUN), done = (state==DONE).
- IDLE, start=1: load a_sh<=a, b_sh<=b, c_reg<=cin, cnt<=0. Go to RUN.
- IDLE, start=0: stay. Outputs hold.
- RUN, every edge:
  - Cell inputs are a_sh[0], b_sh[0] and c_reg.
  - The cell's sum bit shifts into the MSB of s_sh; s_sh shifts right.
  - c_reg <= cell carry. a_sh and b_sh shift right. cnt <= cnt+1.
- RUN, edge with cnt==WIDTH-1: this is the last bit.
  - sum <= final s_sh contents including this bit; cout <= cell carry.
  - Go to DONE.
- DONE, start=1: accept new operands exactly as in IDLE. Go to RUN. This allows back-to-back operation.
- DONE, start=0: go to IDLE.
- start is ignored in RUN. Operand changes during RUN have no effect.
- sum and cout change only on the completing edge. They hold across later starts until the next completion.
- cnt width is $clog2(WIDTH). It never wraps within an operation.
- Reset, at any time including mid-RUN:
  - state=IDLE, busy=0, done=0, sum=0, cout=0.
  - a_sh, b_sh, s_sh, c_reg and cnt all cleared.
  - The in-flight operation is abandoned and no done pulse is issued.

## Timing
- Let start be sampled at edge E0. busy=1 from E0 up to edge E0+WIDTH.
- done=1 and sum/cout are valid from edge E0+WIDTH up to edge E0+WIDTH+1.
- Latency from the accepting edge to done is WIDTH cycles.
- Throughput is one result per WIDTH+1 cycles, with start asserted in the DONE cycle.
- With start held high continuously, operations repeat back-to-back. Operands are re-sampled at each DONE edge.
- Reset release: the first start is sampled on the first rising edge with rst=0.

## Structure
- Shared package/include serial_add_pkg holds:
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the default WIDTH constant.
- Sub-module: bit_full_adder (a, b, ci -> s, co).
  - It uses two instances of the team's existing half adder, with co = carry1 | carry2.
  - It is instantiated once; it is the shared datapath the controller sequences.
- The controller holds the FSM, counter and shift registers.

## Test plan
All scenarios use WIDTH=8.
- Zero operands: a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0. done pulses for exactly 1 cycle at E0+8. busy is high for 8 cycles.
- Full ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
- Carry-in path: a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1. Then a=0xA5, b=0x5A, cin=0 -> sum=0xFF, cout=0.
- Start ignored while busy:
  - Stimulus: a=0x3C, b=0x42, cin=0. Hold start=1 and drive a=0xFF, b=0xFF during RUN.
  - Required: sum=0x7E, cout=0 at first done. The second operation re-samples at the DONE edge.
- Back-to-back:
  - Stimulus: 0x80+0x80, then start in the DONE cycle with 0x12+0x34.
  - Required: sum=0x00, cout=1 at E0+8, then sum=0x46, cout=0 at E0+17.
- Reset mid-operation:
  - Stimulus: rst asserted asynchronously between E0+3 and E0+4.
  - Required: busy, done, sum and cout go to 0 immediately, with no done pulse.
  - After release, 0x01+0x02 -> sum=0x03, cout=0.
